dma_stream_engine: RTL and testbench

DMA_STREAM_ENGINE -- requirements
Module: dma_stream_engine

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_sync_fifo.sv | 52 +++++
 rtl/dma_stream_engine.sv | 203 ++++++++++++++++++++
 tb/tb_dma_stream_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA stream engine:
// FSM state encodings and register indices.
package dma_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_DATA = 2'd2
    } wr_state_t;

    localparam logic [2:0] REG_SRC  = 3'd0;
    localparam logic [2:0] REG_DST  = 3'd1;
    localparam logic [2:0] REG_TAIL = 3'd2;
    localparam logic [2:0] REG_HEAD = 3'd3;
    localparam logic [2:0] REG_SIZE = 3'd4;
    localparam logic [2:0] REG_CTRL = 3'd5;

endpackage

// File: rtl/dma_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count, used as the
// read-to-write staging buffer of the DMA engine.
module dma_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [AW:0]           r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign w_push  = i_push && (r_cnt != (AW+1)'(FIFO_DEPTH));
    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_rdata = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dma_stream_engine.sv
// Descriptor-driven DMA copy engine: burst reads into a FIFO, burst writes out.
// Define DMA_RING_WRAP_EN to wrap tail_ptr within a RING_BYTES ring.
module dma_stream_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
`ifdef DMA_RING_WRAP_EN
    parameter int RING_BYTES = 4096,
`endif
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            reg_wr_en,
    input  logic [31:0]           reg_wr_data,
    input  logic [2:0]            reg_rd_sel,
    output logic [31:0]           reg_rd_data,
    output logic                  intr,
    output logic [31:0]           rd_req_addr,
    output logic [7:0]            rd_req_len,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  rd_valid,
    input  logic                  rd_last,
    output logic                  rd_ready,
    output logic [31:0]           wr_req_addr,
    output logic [7:0]            wr_req_len,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_valid,
    output logic                  wr_last,
    input  logic                  wr_ready
);

    localparam int BPB     = DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int BB      = MAX_BURST * BPB;
    localparam int LOG_BB  = $clog2(BB);
    localparam logic [7:0] MB8 = 8'(MAX_BURST);

    logic [31:0] r_src, r_dst, r_tail, r_head, r_size, r_ctrl;
    logic [31:0] r_base, r_dsize, r_nb, r_rd_k, r_wr_k;
    logic [7:0]  r_lastb, r_wbeat;
    rd_state_t   r_rd_st, w_rd_nxt;
    wr_state_t   r_wr_st, w_wr_nxt;

    logic                  w_start, w_push, w_pop, w_done;
    logic                  w_rd_final, w_wr_final;
    logic [31:0]           w_rem, w_nb, w_free, w_tail_nxt;
    logic [7:0]            w_lastb, w_rd_beats, w_wr_beats;
    logic [$clog2(FIFO_DEPTH):0] w_cnt;

    assign w_start = r_ctrl[0] && (r_head != r_tail) && (r_size != '0)
                     && (r_rd_st == R_IDLE) && (r_wr_st == W_IDLE);

    assign w_rem   = r_size & 32'(BB - 1);
    assign w_nb    = (r_size >> LOG_BB) + {31'b0, w_rem != '0};
    assign w_lastb = (w_rem == '0) ? MB8
                     : 8'((w_rem + 32'(BPB - 1)) >> LOG_BPB);

    assign w_rd_final = (r_rd_k == r_nb - 32'd1);
    assign w_wr_final = (r_wr_k == r_nb - 32'd1);
    assign w_rd_beats = w_rd_final ? r_lastb : MB8;
    assign w_wr_beats = w_wr_final ? r_lastb : MB8;
    assign w_free     = 32'(FIFO_DEPTH) - 32'(w_cnt);

    assign w_push = rd_valid && rd_ready;
    assign w_pop  = wr_valid && wr_ready;
    assign w_done = wr_valid && wr_ready && wr_last && w_wr_final;

`ifdef DMA_RING_WRAP_EN
    assign w_tail_nxt = (r_tail + r_dsize) & 32'(RING_BYTES - 1);
`else
    assign w_tail_nxt = r_tail + r_dsize;
`endif

    assign rd_req_addr = r_src + r_base + (r_rd_k << LOG_BB);
    assign wr_req_addr = r_dst + r_base + (r_wr_k << LOG_BB);
    assign rd_req_len  = w_rd_beats - 8'd1;
    assign wr_req_len  = w_wr_beats - 8'd1;
    assign intr        = r_ctrl[31];

    dma_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_wdata (rd_rdata),
        .i_pop   (w_pop),
        .o_rdata (wr_data),
        .o_count (w_cnt)
    );

    always_comb begin
        reg_rd_data = '0;
        case (reg_rd_sel)
            REG_SRC:  reg_rd_data = r_src;
            REG_DST:  reg_rd_data = r_dst;
            REG_TAIL: reg_rd_data = r_tail;
            REG_HEAD: reg_rd_data = r_head;
            REG_SIZE: reg_rd_data = r_size;
            REG_CTRL: reg_rd_data = r_ctrl;
            default:  reg_rd_data = '0;
        endcase
    end

    // Credit check: a read burst is only requested when the FIFO can absorb it.
    always_comb begin
        w_rd_nxt     = r_rd_st;
        rd_req_valid = 1'b0;
        rd_ready     = 1'b0;
        case (r_rd_st)
            R_IDLE: if (w_start) w_rd_nxt = R_REQ;
            R_REQ: begin
                rd_req_valid = (w_free >= 32'(w_rd_beats));
                if (rd_req_valid && rd_req_ready) w_rd_nxt = R_DATA;
            end
            R_DATA: begin
                rd_ready = 1'b1;
                if (rd_valid && rd_last)
                    w_rd_nxt = w_rd_final ? R_IDLE : R_REQ;
            end
            default: w_rd_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_nxt     = r_wr_st;
        wr_req_valid = 1'b0;
        wr_valid     = 1'b0;
        wr_last      = 1'b0;
        case (r_wr_st)
            W_IDLE: if (w_start) w_wr_nxt = W_REQ;
            W_REQ: begin
                wr_req_valid = (32'(w_cnt) >= 32'(w_wr_beats));
                if (wr_req_valid && wr_req_ready) w_wr_nxt = W_DATA;
            end
            W_DATA: begin
                wr_valid = 1'b1;
                wr_last  = (r_wbeat == wr_req_len);
                if (wr_ready && wr_last)
                    w_wr_nxt = w_wr_final ? W_IDLE : W_REQ;
            end
            default: w_wr_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_st <= R_IDLE;
            r_wr_st <= W_IDLE;
            r_base  <= '0;
            r_dsize <= '0;
            r_nb    <= '0;
            r_lastb <= '0;
            r_rd_k  <= '0;
            r_wr_k  <= '0;
            r_wbeat <= '0;
        end else begin
            r_rd_st <= w_rd_nxt;
            r_wr_st <= w_wr_nxt;
            if (w_start) begin
                r_base  <= r_tail;
                r_dsize <= r_size;
                r_nb    <= w_nb;
                r_lastb <= w_lastb;
                r_rd_k  <= '0;
                r_wr_k  <= '0;
            end
            if (w_push && rd_last && !w_rd_final) r_rd_k <= r_rd_k + 32'd1;
            if (wr_req_valid && wr_req_ready) r_wbeat <= '0;
            else if (w_pop) r_wbeat <= r_wbeat + 8'd1;
            if (w_pop && wr_last && !w_wr_final) r_wr_k <= r_wr_k + 32'd1;
        end
    end

    // Software writes override same-cycle hardware updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_tail <= '0;
            r_head <= '0;
            r_size <= '0;
            r_ctrl <= 32'h0000_0001;
        end else begin
            if (reg_wr_en[0]) r_src  <= reg_wr_data;
            if (reg_wr_en[1]) r_dst  <= reg_wr_data;
            if (reg_wr_en[3]) r_head <= reg_wr_data;
            if (reg_wr_en[4]) r_size <= reg_wr_data;
            if (reg_wr_en[2])  r_tail <= reg_wr_data;
            else if (w_done)   r_tail <= w_tail_nxt;
            if (reg_wr_en[5])  r_ctrl <= reg_wr_data;
            else if (w_done)   r_ctrl[31] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed bench for dma_stream_engine with a read-memory responder
// and a write-side logger; data pattern is address XOR a constant.
module tb_dma_stream_engine;

    localparam logic [31:0] K    = 32'h5A5A_0000;
    localparam logic [31:0] SRC  = 32'h0000_1000;
    localparam logic [31:0] DST  = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  reg_wr_en = '0;
    logic [31:0] reg_wr_data = '0;
    logic [2:0]  reg_rd_sel = '0;
    logic [31:0] reg_rd_data;
    logic        intr;
    logic [31:0] rd_req_addr;
    logic [7:0]  rd_req_len;
    logic        rd_req_valid;
    logic        rd_req_ready = 1'b1;
    logic [31:0] rd_rdata = '0;
    logic        rd_valid = 1'b0;
    logic        rd_last = 1'b0;
    logic        rd_ready;
    logic [31:0] wr_req_addr;
    logic [7:0]  wr_req_len;
    logic        wr_req_valid;
    logic        wr_req_ready = 1'b1;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready = 1'b1;

    int n_tot = 0;
    int n_bad = 0;

    logic [31:0] rq_addr[$];
    logic [7:0]  rq_len[$];
    logic [31:0] wq_addr[$];
    logic [7:0]  wq_len[$];
    logic [31:0] wd[$];
    logic        wl[$];

    always #5 clk = ~clk;

    dma_stream_engine #(
        .DATA_WIDTH (32),
        .MAX_BURST  (8),
`ifdef DMA_RING_WRAP_EN
        .RING_BYTES (256),
`endif
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_sel   (reg_rd_sel),
        .reg_rd_data  (reg_rd_data),
        .intr         (intr),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rdata     (rd_rdata),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_len   (wr_req_len),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read memory responder: one outstanding burst, data = addr ^ K.
    initial begin : rd_agent
        logic        rf, bf;
        logic [31:0] a, ra_addr;
        logic [7:0]  l;
        int          ra_idx, ra_n;
        bit          busy;
        busy = 0; ra_addr = '0; ra_idx = 0; ra_n = 0;
        forever begin
            @(negedge clk);
            rf = rd_req_valid && rd_req_ready;
            bf = rd_valid && rd_ready;
            a  = rd_req_addr;
            l  = rd_req_len;
            @(posedge clk);
            #1;
            if (!rst) begin
                busy = 0;
            end else if (rf) begin
                rq_addr.push_back(a);
                rq_len.push_back(l);
                busy = 1; ra_addr = a; ra_idx = 0; ra_n = int'(l) + 1;
            end else if (bf) begin
                ra_idx++;
                if (ra_idx == ra_n) busy = 0;
            end
            rd_valid = busy;
            rd_rdata = (ra_addr + 32'(4 * ra_idx)) ^ K;
            rd_last  = busy && (ra_idx == ra_n - 1);
        end
    end

    initial begin : wr_logger
        forever begin
            @(negedge clk);
            if (rst && wr_req_valid && wr_req_ready) begin
                wq_addr.push_back(wr_req_addr);
                wq_len.push_back(wr_req_len);
            end
            if (rst && wr_valid && wr_ready) begin
                wd.push_back(wr_data);
                wl.push_back(wr_last);
            end
        end
    end

    task automatic wreg(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        reg_wr_en   = 6'(1 << idx);
        reg_wr_data = d;
        @(posedge clk); #1;
        reg_wr_en   = '0;
    endtask

    task automatic rreg(input logic [2:0] s, output logic [31:0] v);
        @(posedge clk); #1;
        reg_rd_sel = s;
        @(negedge clk);
        v = reg_rd_data;
    endtask

    task automatic clear_logs();
        rq_addr.delete(); rq_len.delete();
        wq_addr.delete(); wq_len.delete();
        wd.delete(); wl.delete();
    endtask

    task automatic wait_intr(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (intr) break;
        end
        chk(tag, {31'b0, intr}, 32'd1);
    endtask

    task automatic wait_wlast();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (wr_valid && wr_ready && wr_last) break;
        end
    endtask

    task automatic chk_data(input string tag, input logic [31:0] off,
                            input int n);
        chk({tag, "_nbeats"}, 32'(wd.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_d%0d", tag, i), wd[i],
                (SRC + off + 32'(4 * i)) ^ K);
    endtask

    logic [31:0] v;
    int          nl;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        rreg(3'd5, v); chk("rst_ctrl", v, 32'h1);
        rreg(3'd2, v); chk("rst_tail", v, 32'h0);
        rreg(3'd6, v); chk("rsel6", v, 32'h0);
        chk("rst_intr", {31'b0, intr}, 32'd0);
        chk("rst_rqv", {31'b0, rd_req_valid}, 32'd0);
        chk("rst_wv", {31'b0, wr_valid}, 32'd0);

        // 64 bytes -> two full bursts
        clear_logs();
        wreg(0, SRC); wreg(1, DST); wreg(4, 64); wreg(3, 64);
        wait_intr("t1_done");
        chk("t1_nrq", 32'(rq_addr.size()), 32'd2);
        chk("t1_ra0", rq_addr[0], 32'h1000);
        chk("t1_rl0", 32'(rq_len[0]), 32'd7);
        chk("t1_ra1", rq_addr[1], 32'h1020);
        chk("t1_rl1", 32'(rq_len[1]), 32'd7);
        chk("t1_wa0", wq_addr[0], 32'h8000);
        chk("t1_wa1", wq_addr[1], 32'h8020);
        chk("t1_wl1", 32'(wq_len[1]), 32'd7);
        chk_data("t1", 32'd0, 16);
        nl = 0;
        foreach (wl[i]) if (wl[i]) nl++;
        chk("t1_nlast", 32'(nl), 32'd2);
        chk("t1_last7", {31'b0, wl[7]}, 32'd1);
        rreg(3'd2, v); chk("t1_tail", v, 32'd64);
        wreg(5, 32'h1);
        chk("t1_intr_clr", {31'b0, intr}, 32'd0);

        // 40 bytes -> len 7 then len 1
        clear_logs();
        wreg(4, 40); wreg(3, 104);
        wait_intr("t2_done");
        chk("t2_nrq", 32'(rq_addr.size()), 32'd2);
        chk("t2_ra0", rq_addr[0], 32'h1040);
        chk("t2_rl0", 32'(rq_len[0]), 32'd7);
        chk("t2_ra1", rq_addr[1], 32'h1060);
        chk("t2_rl1", 32'(rq_len[1]), 32'd1);
        chk("t2_wa1", wq_addr[1], 32'h8060);
        chk("t2_wl1", 32'(wq_len[1]), 32'd1);
        chk_data("t2", 32'd64, 10);
        rreg(3'd2, v); chk("t2_tail", v, 32'd104);
        wreg(5, 32'h1);

        // 3 bytes -> one beat
        clear_logs();
        wreg(4, 3); wreg(3, 107);
        wait_intr("t3_done");
        chk("t3_nrq", 32'(rq_addr.size()), 32'd1);
        chk("t3_ra0", rq_addr[0], 32'h1068);
        chk("t3_rl0", 32'(rq_len[0]), 32'd0);
        chk("t3_wl0", 32'(wq_len[0]), 32'd0);
        chk_data("t3", 32'd104, 1);
        rreg(3'd2, v); chk("t3_tail", v, 32'd107);
        wreg(5, 32'h1);

        // write side stalled: second read withheld until FIFO drains
        clear_logs();
        @(posedge clk); #1 wr_ready = 1'b0;
        wreg(4, 64); wreg(3, 171);
        repeat (20) @(negedge clk);
        chk("t4_stall_nrq", 32'(rq_addr.size()), 32'd1);
        chk("t4_stall_rqv", {31'b0, rd_req_valid}, 32'd0);
        chk("t4_stall_wv", {31'b0, wr_valid}, 32'd1);
        @(posedge clk); #1 wr_ready = 1'b1;
        wait_intr("t4_done");
        chk("t4_nrq", 32'(rq_addr.size()), 32'd2);
        chk("t4_ra1", rq_addr[1], 32'h108B);
        chk("t4_wa0", wq_addr[0], 32'h806B);
        chk_data("t4", 32'd107, 16);
        rreg(3'd2, v); chk("t4_tail", v, 32'd171);
        wreg(5, 32'h1);

        // ctrl write in completion cycle keeps intr clear
        wreg(4, 4); wreg(3, 175);
        wait_wlast();
        chk("t5_seen", {31'b0, wr_last}, 32'd1);
        reg_wr_en = 6'b100000; reg_wr_data = 32'h1;
        @(posedge clk); #1 reg_wr_en = '0;
        @(negedge clk);
        chk("t5_intr", {31'b0, intr}, 32'd0);
        rreg(3'd5, v); chk("t5_ctrl", v, 32'h1);
        rreg(3'd2, v); chk("t5_tail", v, 32'd175);

        // tail write in completion cycle wins over hw advance
        wreg(3, 200);
        wait_wlast();
        chk("t6_seen", {31'b0, wr_last}, 32'd1);
        reg_wr_en = 6'b000100; reg_wr_data = 32'd200;
        @(posedge clk); #1 reg_wr_en = '0;
        @(negedge clk);
        chk("t6_intr", {31'b0, intr}, 32'd1);
        rreg(3'd2, v); chk("t6_tail", v, 32'd200);
        repeat (3) @(negedge clk);
        chk("t6_idle", {31'b0, rd_req_valid | wr_req_valid}, 32'd0);
        wreg(5, 32'h1);

        // reset mid-burst
        @(posedge clk); #1 wr_ready = 1'b0;
        wreg(4, 64); wreg(3, 264);
        repeat (20) @(negedge clk);
        chk("t7_pre_wv", {31'b0, wr_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; reg_rd_sel = 3'd5;
        @(negedge clk);
        chk("t7_rqv", {31'b0, rd_req_valid}, 32'd0);
        chk("t7_rrdy", {31'b0, rd_ready}, 32'd0);
        chk("t7_wqv", {31'b0, wr_req_valid}, 32'd0);
        chk("t7_wv", {31'b0, wr_valid}, 32'd0);
        chk("t7_wl", {31'b0, wr_last}, 32'd0);
        chk("t7_intr", {31'b0, intr}, 32'd0);
        chk("t7_ctrl", reg_rd_data, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_post_v", {31'b0, rd_req_valid | wr_valid | rd_ready}, 32'd0);
        rreg(3'd2, v); chk("t7_tail", v, 32'd0);

`ifdef DMA_RING_WRAP_EN
        clear_logs();
        wreg(0, SRC); wreg(1, DST); wreg(2, 224); wreg(3, 32); wreg(4, 64);
        wait_intr("t8_done");
        chk("t8_ra0", rq_addr[0], 32'h10E0);
        chk("t8_ra1", rq_addr[1], 32'h1100);
        chk("t8_wa1", wq_addr[1], 32'h8100);
        chk_data("t8", 32'd224, 16);
        rreg(3'd2, v); chk("t8_tail", v, 32'd32);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
